modrm_decode: RTL and testbench

//  Upstream operand-fetch stage of the register file. Consumes a ModR/M byte
//  and 0-2 displacement bytes from the instruction byte FIFO, then drives the

---
 rtl/modrm_decode_pkg.sv | 31 +++
 rtl/modrm_decode_ea_select.sv | 46 ++++
 rtl/modrm_decode.sv | 198 +++++++++++++++++++
 tb/tb_modrm_decode.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modrm_decode_pkg.sv
// Shared types and encodings for the ModR/M operand-fetch stage.
// The optional feature macro MODRM_FAST_REG_EN is consumed by modrm_decode.sv.
package modrm_decode_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MODRM   = 3'd1,
        ST_DISP_LO = 3'd2,
        ST_DISP_HI = 3'd3,
        ST_REGREAD = 3'd4,
        ST_CALC    = 3'd5,
        ST_DONE    = 3'd6
    } state_e;

    localparam logic [1:0] MOD_NODISP = 2'b00;
    localparam logic [1:0] MOD_DISP8  = 2'b01;
    localparam logic [1:0] MOD_DISP16 = 2'b10;
    localparam logic [1:0] MOD_REG    = 2'b11;

    localparam logic [2:0] REG_BX = 3'd3;
    localparam logic [2:0] REG_BP = 3'd5;
    localparam logic [2:0] REG_SI = 3'd6;
    localparam logic [2:0] REG_DI = 3'd7;

    localparam logic [2:0] RM_DIRECT = 3'b110;

    function automatic logic [15:0] sign_ext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/modrm_decode_ea_select.sv
// Combinational rm/mod decode into register-file selects and addressing flags.
module modrm_ea_select
    import modrm_decode_pkg::*;
(
    input  logic [1:0] mod_i,
    input  logic [2:0] rm_i,
    output logic [2:0] base_sel_o,
    output logic [2:0] index_sel_o,
    output logic       index_valid_o,
    output logic       bp_as_base_o,
    output logic       direct_o
);

    // Base/index pair for each rm encoding
    always_comb begin
        base_sel_o    = REG_BX;
        index_sel_o   = 3'd0;
        index_valid_o = 1'b0;
        case (rm_i)
            3'b000: begin base_sel_o = REG_BX; index_sel_o = REG_SI; index_valid_o = 1'b1; end
            3'b001: begin base_sel_o = REG_BX; index_sel_o = REG_DI; index_valid_o = 1'b1; end
            3'b010: begin base_sel_o = REG_BP; index_sel_o = REG_SI; index_valid_o = 1'b1; end
            3'b011: begin base_sel_o = REG_BP; index_sel_o = REG_DI; index_valid_o = 1'b1; end
            3'b100: base_sel_o = REG_SI;
            3'b101: base_sel_o = REG_DI;
            3'b110: base_sel_o = REG_BP;
            3'b111: base_sel_o = REG_BX;
            default: base_sel_o = REG_BX;
        endcase
    end

    // rm 110 with mod 00 is a direct address, so BP is not involved there
    always_comb begin
        direct_o = (mod_i == MOD_NODISP) && (rm_i == RM_DIRECT);
        if (mod_i == MOD_REG) begin
            bp_as_base_o = 1'b0;
        end else if ((rm_i == 3'b010) || (rm_i == 3'b011)) begin
            bp_as_base_o = 1'b1;
        end else if (rm_i == RM_DIRECT) begin
            bp_as_base_o = (mod_i == MOD_DISP8) || (mod_i == MOD_DISP16);
        end else begin
            bp_as_base_o = 1'b0;
        end
    end

endmodule

// File: rtl/modrm_decode.sv
// ModR/M + displacement fetch, register-file read and 16-bit EA computation.
// Optional MODRM_FAST_REG_EN: mod 11 skips REGREAD/CALC and completes straight from MODRM.
module modrm_decode
    import modrm_decode_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  clear,
    input  logic                  fifo_empty,
    input  logic [7:0]            fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [2:0]            rf_rd_sel [2],
    input  logic [ADDR_WIDTH-1:0] rf_rd_val [2],
    output logic [2:0]            reg_field,
    output logic [2:0]            rm_field,
    output logic                  rm_is_reg,
    output logic                  bp_as_base,
    output logic [ADDR_WIDTH-1:0] effective_addr,
    output logic                  busy,
    output logic                  complete
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};

    state_e                state_q, state_d;
    logic [1:0]            mod_q, mod_d;
    logic [2:0]            reg_q, reg_d;
    logic [2:0]            rm_q, rm_d;
    logic                  is_reg_q, is_reg_d;
    logic                  bp_q, bp_d;
    logic [ADDR_WIDTH-1:0] disp_q, disp_d;
    logic [ADDR_WIDTH-1:0] ea_q, ea_d;
    logic                  busy_q, complete_q;
    logic [2:0]            rf_sel_q [2];
    logic [2:0]            rf_sel_d [2];

    logic [1:0]            sel_mod_s;
    logic [2:0]            sel_rm_s;
    logic [2:0]            base_sel_s, index_sel_s;
    logic                  index_valid_s, bp_sel_s, direct_s;
    logic                  byte_state_s;
    logic [ADDR_WIDTH-1:0] index_val_s;

    // While in MODRM the decode looks at the byte being popped, afterwards at the latched fields
    assign sel_mod_s = (state_q == ST_MODRM) ? fifo_rd_data[7:6] : mod_q;
    assign sel_rm_s  = (state_q == ST_MODRM) ? fifo_rd_data[2:0] : rm_q;

    modrm_ea_select u_ea_select (
        .mod_i         (sel_mod_s),
        .rm_i          (sel_rm_s),
        .base_sel_o    (base_sel_s),
        .index_sel_o   (index_sel_s),
        .index_valid_o (index_valid_s),
        .bp_as_base_o  (bp_sel_s),
        .direct_o      (direct_s)
    );

    assign byte_state_s = (state_q == ST_MODRM) || (state_q == ST_DISP_LO) || (state_q == ST_DISP_HI);
    assign fifo_rd_en   = byte_state_s && !fifo_empty && !clear;

    // Next-state and latched-field logic
    always_comb begin
        state_d     = state_q;
        mod_d       = mod_q;
        reg_d       = reg_q;
        rm_d        = rm_q;
        is_reg_d    = is_reg_q;
        bp_d        = bp_q;
        disp_d      = disp_q;
        ea_d        = ea_q;
        index_val_s = index_valid_s ? rf_rd_val[1] : ADDR_ZERO;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_MODRM;
                    else       state_d = ST_IDLE;
                end
                ST_MODRM: begin
                    if (fifo_rd_en) begin
                        mod_d    = fifo_rd_data[7:6];
                        reg_d    = fifo_rd_data[5:3];
                        rm_d     = fifo_rd_data[2:0];
                        is_reg_d = (fifo_rd_data[7:6] == MOD_REG);
                        bp_d     = bp_sel_s;
                        disp_d   = ADDR_ZERO;
                        if ((fifo_rd_data[7:6] == MOD_DISP8) || (fifo_rd_data[7:6] == MOD_DISP16) || direct_s) begin
                            state_d = ST_DISP_LO;
                        end else if (fifo_rd_data[7:6] == MOD_REG) begin
`ifdef MODRM_FAST_REG_EN
                            ea_d    = ADDR_ZERO;
                            state_d = ST_DONE;
`else
                            state_d = ST_REGREAD;
`endif
                        end else begin
                            state_d = ST_REGREAD;
                        end
                    end else begin
                        state_d = ST_MODRM;
                    end
                end
                ST_DISP_LO: begin
                    if (fifo_rd_en) begin
                        if (mod_q == MOD_DISP8) begin
                            disp_d  = sign_ext8(fifo_rd_data);
                            state_d = ST_REGREAD;
                        end else begin
                            disp_d  = {8'h00, fifo_rd_data};
                            state_d = ST_DISP_HI;
                        end
                    end else begin
                        state_d = ST_DISP_LO;
                    end
                end
                ST_DISP_HI: begin
                    if (fifo_rd_en) begin
                        disp_d = {fifo_rd_data, disp_q[7:0]};
                        if (direct_s) begin
                            ea_d    = {fifo_rd_data, disp_q[7:0]};
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_REGREAD;
                        end
                    end else begin
                        state_d = ST_DISP_HI;
                    end
                end
                ST_REGREAD: state_d = ST_CALC;
                ST_CALC: begin
                    if (is_reg_q) ea_d = ADDR_ZERO;
                    else          ea_d = rf_rd_val[0] + index_val_s + disp_q;
                    state_d = ST_DONE;
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Register-file selects are only driven for the REGREAD cycle
    always_comb begin
        if (state_d == ST_REGREAD) begin
            rf_sel_d[0] = base_sel_s;
            if (index_valid_s) rf_sel_d[1] = index_sel_s;
            else               rf_sel_d[1] = 3'd0;
        end else begin
            rf_sel_d[0] = 3'd0;
            rf_sel_d[1] = 3'd0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            mod_q       <= 2'b00;
            reg_q       <= 3'd0;
            rm_q        <= 3'd0;
            is_reg_q    <= 1'b0;
            bp_q        <= 1'b0;
            disp_q      <= ADDR_ZERO;
            ea_q        <= ADDR_ZERO;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
            rf_sel_q[0] <= 3'd0;
            rf_sel_q[1] <= 3'd0;
        end else begin
            state_q     <= state_d;
            mod_q       <= mod_d;
            reg_q       <= reg_d;
            rm_q        <= rm_d;
            is_reg_q    <= is_reg_d;
            bp_q        <= bp_d;
            disp_q      <= disp_d;
            ea_q        <= ea_d;
            busy_q      <= (state_d != ST_IDLE);
            complete_q  <= (state_d == ST_DONE);
            rf_sel_q[0] <= rf_sel_d[0];
            rf_sel_q[1] <= rf_sel_d[1];
        end
    end

    assign rf_rd_sel[0]   = rf_sel_q[0];
    assign rf_rd_sel[1]   = rf_sel_q[1];
    assign reg_field      = reg_q;
    assign rm_field       = rm_q;
    assign rm_is_reg      = is_reg_q;
    assign bp_as_base     = bp_q;
    assign effective_addr = ea_q;
    assign busy           = busy_q;
    assign complete       = complete_q;

endmodule

// File: tb/tb_modrm_decode.sv
// Randomized bench for modrm_decode against a transaction-level model of latency and EA.
module tb_modrm_decode;

`ifdef MODRM_FAST_REG_EN
    localparam int FAST_LAT = 2;
`else
    localparam int FAST_LAT = 4;
`endif
    // rm -> base / index register number (AX0 CX1 DX2 BX3 SP4 BP5 SI6 DI7)
    localparam int BASE_T [8] = '{3, 3, 5, 5, 6, 7, 5, 3};
    localparam int IDX_T  [8] = '{6, 7, 6, 7, 0, 0, 0, 0};
    localparam int IDXV_T [8] = '{1, 1, 1, 1, 0, 0, 0, 0};

    logic        clk = 1'b0;
    logic        reset_n, start, clear, fifo_empty, fifo_rd_en;
    logic [7:0]  fifo_rd_data;
    logic [2:0]  rf_rd_sel [2];
    logic [15:0] rf_rd_val [2];
    logic [2:0]  reg_field, rm_field;
    logic        rm_is_reg, bp_as_base, busy, complete;
    logic [15:0] effective_addr;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    logic [15:0] regs [8];
    logic [7:0]  fq [$];
    int          fst [$];
    bit          p_s, b_s;

    bit          chk_en = 1'b0, act = 1'b0, hv = 1'b0, no_rr = 1'b0;
    int          t0 = 0, exp_cyc = -1, busy_end = -1, rr_cyc = -1, last_cmp_cyc = -1;
    logic [2:0]  e_base, e_idx, h_reg, h_rm;
    bit          e_idxv, h_isreg, h_bp;
    logic [15:0] h_ea;
    bit          ce, be;

    modrm_decode #(.ADDR_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .clear(clear),
        .fifo_empty(fifo_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
        .rf_rd_sel(rf_rd_sel), .rf_rd_val(rf_rd_val),
        .reg_field(reg_field), .rm_field(rm_field), .rm_is_reg(rm_is_reg),
        .bp_as_base(bp_as_base), .effective_addr(effective_addr),
        .busy(busy), .complete(complete)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        rf_rd_val[0] <= regs[rf_rd_sel[0]];
        rf_rd_val[1] <= regs[rf_rd_sel[1]];
    end

    function automatic void chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act_v, exp_v);
        end
    endfunction

    function automatic void fifo_upd();
        if (fq.size() == 0) begin
            fifo_empty   = 1'b1;
            fifo_rd_data = 8'h00;
        end else begin
            fifo_empty   = (fst[0] != 0);
            fifo_rd_data = fq[0];
        end
    endfunction

    // Show-ahead FIFO: head byte stalls for its programmed number of busy cycles
    always @(posedge clk) begin
        p_s = fifo_rd_en;
        b_s = busy;
        #1;
        if (fq.size() > 0) begin
            if (p_s) begin
                void'(fq.pop_front());
                void'(fst.pop_front());
            end else if (b_s && fst[0] > 0) begin
                fst[0] = fst[0] - 1;
            end
        end
        fifo_upd();
    end

    // Per-cycle comparison against the expectation of the current transaction
    always begin
        @(negedge clk);
        #2;
        if (chk_en) begin
            ce = act && (cyc == exp_cyc);
            be = act && (cyc > t0) && (cyc <= busy_end);
            chk("complete", complete, ce);
            chk("busy", busy, be);
            if (fifo_empty) chk("pop_while_empty", fifo_rd_en, 0);
            if (clear)      chk("pop_on_clear", fifo_rd_en, 0);
            if (complete)   last_cmp_cyc = cyc;
            if (act && cyc == rr_cyc) begin
                chk("rf_sel0", rf_rd_sel[0], e_base);
                if (e_idxv) chk("rf_sel1", rf_rd_sel[1], e_idx);
            end
            if (act && no_rr && be) begin
                chk("rf_sel0_idle", rf_rd_sel[0], 0);
                chk("rf_sel1_idle", rf_rd_sel[1], 0);
            end
            if (act && hv && cyc >= exp_cyc) begin
                chk("reg_field", reg_field, h_reg);
                chk("rm_field", rm_field, h_rm);
                chk("rm_is_reg", rm_is_reg, h_isreg);
                chk("bp_as_base", bp_as_base, h_bp);
                chk("ea", effective_addr, h_ea);
            end
        end
    end

    task automatic run_txn(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int s0, input int s1, input int s2, input int clr_off, input int hold,
                           input int lit_lat, input int lit_ea, input int lit_left);
        logic [1:0]  md;
        logic [2:0]  rm;
        bit          dir, rr;
        int          nb, lat, kmax;
        int          stl [3];
        logic [15:0] disp, ea;
        md  = b0[7:6];
        rm  = b0[2:0];
        dir = (md == 2'b00) && (rm == 3'b110);
        nb  = (md == 2'b01) ? 2 : ((md == 2'b10) || dir) ? 3 : 1;
        stl = '{s0, s1, s2};
        case (md)
            2'b00:   lat = 4;
            2'b01:   lat = 5;
            2'b10:   lat = 6;
            default: lat = FAST_LAT;
        endcase
        for (int i = 0; i < nb; i++) lat += stl[i];
        if (md == 2'b01)              disp = {{8{b1[7]}}, b1};
        else if (md == 2'b10 || dir)  disp = {b2, b1};
        else                          disp = 16'h0000;
        if (md == 2'b11)  ea = 16'h0000;
        else if (dir)     ea = disp;
        else              ea = regs[BASE_T[rm]] + ((IDXV_T[rm] != 0) ? regs[IDX_T[rm]] : 16'h0000) + disp;
        rr = !dir && !((md == 2'b11) && (FAST_LAT == 2));
        fq.push_back(b0); fst.push_back(s0);
        if (nb > 1) begin fq.push_back(b1); fst.push_back(s1); end
        if (nb > 2) begin fq.push_back(b2); fst.push_back(s2); end
        fifo_upd();
        @(negedge clk);
        t0       = cyc;
        exp_cyc  = t0 + lat;
        busy_end = exp_cyc;
        rr_cyc   = rr ? exp_cyc - 2 : -1;
        no_rr    = !rr;
        e_base   = 3'(BASE_T[rm]);
        e_idx    = 3'(IDX_T[rm]);
        e_idxv   = (IDXV_T[rm] != 0);
        h_reg    = b0[5:3];
        h_rm     = rm;
        h_isreg  = (md == 2'b11);
        h_bp     = (md != 2'b11) && ((rm == 3'b010) || (rm == 3'b011) || (rm == 3'b110 && md != 2'b00));
        h_ea     = ea;
        hv       = 1'b1;
        act      = 1'b1;
        last_cmp_cyc = -1;
        start    = 1'b1;
        kmax = (clr_off > 0) ? clr_off + 1 : lat + 1;
        for (int k = 1; k <= kmax; k++) begin
            @(negedge clk);
            start = (k <= hold);
            clear = (k == clr_off);
            if (clear) begin
                busy_end = t0 + k;
                exp_cyc  = -1;
                hv       = 1'b0;
                if (rr_cyc > t0 + k) rr_cyc = -1;
            end
        end
        start = 1'b0;
        clear = 1'b0;
        if (lit_left >= 0) chk("lit_unpopped", fq.size(), lit_left);
        if (clr_off > 0) begin
            fq.delete(); fst.delete(); fifo_upd();
        end else begin
            chk("fifo_drained", fq.size(), 0);
        end
        if (lit_lat >= 0) chk("lit_latency", last_cmp_cyc - t0, lit_lat);
        if (lit_ea >= 0) begin
            chk("lit_ea", effective_addr, lit_ea);
            chk("model_ea", ea, lit_ea);
        end
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_complete"}, complete, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_rd_en"}, fifo_rd_en, 0);
        chk({tag, "_sel0"}, rf_rd_sel[0], 0);
        chk({tag, "_sel1"}, rf_rd_sel[1], 0);
        chk({tag, "_reg"}, reg_field, 0);
        chk({tag, "_rm"}, rm_field, 0);
        chk({tag, "_isreg"}, rm_is_reg, 0);
        chk({tag, "_bp"}, bp_as_base, 0);
        chk({tag, "_ea"}, effective_addr, 0);
    endtask

    initial begin
        logic [7:0] rb0, rb1, rb2;
        int co, ho, lt;
        reset_n = 1'b0; start = 1'b0; clear = 1'b0;
        for (int r = 0; r < 8; r++) regs[r] = 16'h0000;
        fifo_upd();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        regs[3] = 16'h1234;
        run_txn(8'h07, 8'h00, 8'h00, 0, 0, 0, -1, 0, 4, 16'h1234, -1);
        chk("t1_bp", bp_as_base, 0);
        regs[5] = 16'h0100; regs[6] = 16'h0010;
        run_txn(8'h42, 8'hFE, 8'h00, 0, 0, 0, -1, 0, 5, 16'h010E, -1);
        chk("t2_bp", bp_as_base, 1);
        run_txn(8'h06, 8'h34, 8'h12, 0, 0, 0, -1, 0, 4, 16'h1234, -1);
        regs[3] = 16'h0001;
        run_txn(8'h87, 8'hFF, 8'hFF, 0, 0, 0, -1, 1, 6, 16'h0000, -1);
        regs[3] = 16'h1000; regs[6] = 16'h0001;
        run_txn(8'h80, 8'h10, 8'h20, 0, 0, 3, -1, 0, 9, 16'h3011, -1);
        run_txn(8'h42, 8'h05, 8'h00, 0, 0, 0, 2, 0, -1, -1, 1);
        // start and clear together while idle must not begin a decode
        @(negedge clk);
        t0 = cyc; busy_end = t0; exp_cyc = -1; rr_cyc = -1; no_rr = 1'b1; act = 1'b1;
        start = 1'b1; clear = 1'b1;
        @(negedge clk);
        start = 1'b0; clear = 1'b0;
        repeat (2) @(negedge clk);
        run_txn(8'hC3, 8'h00, 8'h00, 0, 0, 0, -1, 0, FAST_LAT, 16'h0000, -1);
        chk("t6_isreg", rm_is_reg, 1);
        chk("t6_reg", reg_field, 0);
        chk("t6_rm", rm_field, 3);

        for (int n = 0; n < 60; n++) begin
            for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
            rb0 = 8'($urandom); rb1 = 8'($urandom); rb2 = 8'($urandom);
            case (rb0[7:6])
                2'b00:   lt = 4;
                2'b01:   lt = 5;
                2'b10:   lt = 6;
                default: lt = FAST_LAT;
            endcase
            co = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, lt - 1)) : -1;
            ho = (co > 0) ? 0 : int'($urandom_range(0, 2));
            run_txn(rb0, rb1, rb2,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                    co, ho, -1, -1, -1);
        end

        // asynchronous reset in the middle of a disp16 decode
        fq.push_back(8'h80); fst.push_back(0);
        fq.push_back(8'h11); fst.push_back(0);
        fq.push_back(8'h22); fst.push_back(0);
        fifo_upd();
        chk_en = 1'b0;
        act = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_busy", busy, 1);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
